// File: rtl/nn_bram_biu.sv
//------------------------------------------------------------------------------
// nn_bram_biu
//
// Bus-interface unit between the NN sequencer and the single-port weight/input
// BRAM. Sequencer single-word reads (level start / complete handshake) and host
// single-word writes (level request / one-cycle ack) are arbitrated onto one
// synchronous BRAM with a fixed read latency. Reads win a same-cycle collision;
// a write is never allowed to preempt a read that is already in flight.
//
// Requests whose address has any bit set above the physical BRAM address width
// raise the sticky biu_addr_err flag and never touch the BRAM. Such a read still
// completes with the normal latency and returns zero, so the sequencer cannot
// hang; such a write still receives its ack.
//
// Parameters
//   DATA_BIT_NUM    BRAM word width / NN datum width
//   BRAM_ADDR_BIT   width of request addresses (sequencer and host)
//   BRAM_DEPTH_BIT  physical BRAM word-address width
//   BRAM_RD_LAT     cycles from read enable to valid bram_rdata (1..7)
//
// Ports
//   nn_clk, nn_rst_n   clock (posedge) and asynchronous active-low reset
//   nn_start_read      sequencer read request, held until bram_complete is seen
//   nn_bram_addr       sequencer word address, sampled on acceptance
//   nn_bram_read_data  read data, stable while bram_complete is high
//   bram_complete      read done, held until nn_start_read is sampled low
//   host_wr_req        host write request, held until host_wr_ack
//   host_wr_addr       host word address, sampled on acceptance
//   host_wr_data       host write data, sampled on acceptance
//   host_wr_ack        one-cycle pulse when the write is issued
//   biu_addr_err       sticky out-of-range request flag
//   bram_en, bram_we   BRAM enable / write enable
//   bram_addr          BRAM word address
//   bram_wdata         BRAM write data
//   bram_rdata         BRAM read data, valid BRAM_RD_LAT cycles after read enable
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module nn_bram_biu #(
   parameter int DATA_BIT_NUM   = 16,
   parameter int BRAM_ADDR_BIT  = 32,
   parameter int BRAM_DEPTH_BIT = 12,
   parameter int BRAM_RD_LAT    = 2
) (
   input  logic                      nn_clk,
   input  logic                      nn_rst_n,
   // sequencer read port
   input  logic                      nn_start_read,
   input  logic [BRAM_ADDR_BIT-1:0]  nn_bram_addr,
   output logic [DATA_BIT_NUM-1:0]   nn_bram_read_data,
   output logic                      bram_complete,
   // host write port
   input  logic                      host_wr_req,
   input  logic [BRAM_ADDR_BIT-1:0]  host_wr_addr,
   input  logic [DATA_BIT_NUM-1:0]   host_wr_data,
   output logic                      host_wr_ack,
   // status
   output logic                      biu_addr_err,
   // BRAM port
   output logic                      bram_en,
   output logic                      bram_we,
   output logic [BRAM_DEPTH_BIT-1:0] bram_addr,
   output logic [DATA_BIT_NUM-1:0]   bram_wdata,
   input  logic [DATA_BIT_NUM-1:0]   bram_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_DONE,
      WR_ISSUE
   } state_t;

   // Latency counter is 3 bits wide, which covers the legal 1..7 range.
   localparam logic [2:0] RD_LAT_L = 3'(BRAM_RD_LAT);

   state_t     state;
   logic [2:0] lat_cnt;
   logic       rd_oor_q;   // accepted read was out of range: return zero
   logic       rd_oor;
   logic       wr_oor;

   // Out-of-range detection on the live request addresses; only consulted in
   // IDLE on the accepting edge, so later address changes have no effect.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      rd_oor = |nn_bram_addr[BRAM_ADDR_BIT-1:BRAM_DEPTH_BIT];
      wr_oor = |host_wr_addr[BRAM_ADDR_BIT-1:BRAM_DEPTH_BIT];
   end

   // Single registered FSM: every output is a flop, loaded on the edge that
   // enters the state in which it must be visible.
   // NOTE: state and outputs use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge nn_clk or negedge nn_rst_n) begin
      if (!nn_rst_n) begin
         state             <= IDLE;
         lat_cnt           <= '0;
         rd_oor_q          <= 1'b0;
         nn_bram_read_data <= '0;
         bram_complete     <= 1'b0;
         host_wr_ack       <= 1'b0;
         biu_addr_err      <= 1'b0;
         bram_en           <= 1'b0;
         bram_we           <= 1'b0;
         bram_addr         <= '0;
         bram_wdata        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (nn_start_read) begin
                  // Read has priority; a pending host write simply waits.
                  state     <= RD_ISSUE;
                  rd_oor_q  <= rd_oor;
                  bram_en   <= ~rd_oor;
                  bram_we   <= 1'b0;
                  bram_addr <= nn_bram_addr[BRAM_DEPTH_BIT-1:0];
                  if (rd_oor) begin
                     biu_addr_err <= 1'b1;
                  end
               end else if (host_wr_req) begin
                  state       <= WR_ISSUE;
                  bram_en     <= ~wr_oor;
                  bram_we     <= ~wr_oor;
                  bram_addr   <= host_wr_addr[BRAM_DEPTH_BIT-1:0];
                  bram_wdata  <= host_wr_data;
                  host_wr_ack <= 1'b1;
                  if (wr_oor) begin
                     biu_addr_err <= 1'b1;
                  end
               end
            end

            RD_ISSUE: begin
               // Enable was visible for exactly this one cycle.
               bram_en   <= 1'b0;
               bram_addr <= '0;
               lat_cnt   <= RD_LAT_L;
               state     <= RD_WAIT;
            end

            RD_WAIT: begin
               // Counter reaching 1 lines up with bram_rdata becoming valid.
               if (lat_cnt == 3'd1) begin
                  nn_bram_read_data <= rd_oor_q ? '0 : bram_rdata;
                  bram_complete     <= 1'b1;
                  lat_cnt           <= '0;
                  state             <= RD_DONE;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            RD_DONE: begin
               // Hold completion until the sequencer drops its request; the
               // data register keeps its value until the next capture.
               if (!nn_start_read) begin
                  bram_complete <= 1'b0;
                  state         <= IDLE;
               end
            end

            WR_ISSUE: begin
               bram_en     <= 1'b0;
               bram_we     <= 1'b0;
               bram_addr   <= '0;
               bram_wdata  <= '0;
               host_wr_ack <= 1'b0;
               state       <= IDLE;
            end

            default: begin
               state         <= IDLE;
               bram_en       <= 1'b0;
               bram_we       <= 1'b0;
               bram_complete <= 1'b0;
               host_wr_ack   <= 1'b0;
            end
         endcase
      end
   end

   // Protocol invariants tying the registered outputs to the state they belong to.
   a_en_only_in_issue : assert property (@(posedge nn_clk) disable iff (!nn_rst_n)
      bram_en |-> (state == RD_ISSUE || state == WR_ISSUE));
   a_we_only_in_write : assert property (@(posedge nn_clk) disable iff (!nn_rst_n)
      bram_we |-> (state == WR_ISSUE));
   a_ack_only_in_write : assert property (@(posedge nn_clk) disable iff (!nn_rst_n)
      host_wr_ack |-> (state == WR_ISSUE));
   a_complete_in_done : assert property (@(posedge nn_clk) disable iff (!nn_rst_n)
      bram_complete |-> (state == RD_DONE));

endmodule
